alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 57 +++++
 rtl/alu_ctl_decode.sv | 49 ++++
 rtl/alu_exec_unit.sv | 174 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execution unit: funct codes, alu_op, internal op and FSM state.
package alu_pkg;

  // MIPS R-type funct field values
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  // Main-control alu_op encoding
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ZERO  = 2'b11
  } alu_op_e;

  // Internal operation after decode; undecodable functs map to OP_ZERO with illegal set
  typedef enum logic [3:0] {
    OP_ADD,
    OP_ADDU,
    OP_SUB,
    OP_SUBU,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLTU,
    OP_MULT,
    OP_MULTU,
    OP_MFHI,
    OP_MFLO,
    OP_ZERO
  } op_e;

  // Control FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  function automatic logic is_mul_op(input op_e op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALU control: alu_op + funct -> internal op and illegal flag.
module alu_ctl_decode
  import alu_pkg::*;
#(
  parameter int unsigned MUL_EN = 1
) (
  input  logic [1:0] alu_op,
  input  logic [5:0] func_code,
  output op_e        op_c,
  output logic       illegal_c
);

  // Decode; anything not recognised yields a zero result flagged illegal
  always_comb begin
    op_c      = OP_ZERO;
    illegal_c = 1'b0;
    case (alu_op)
      ALUOP_ADD:  op_c = OP_ADD;
      ALUOP_SUB:  op_c = OP_SUB;
      ALUOP_ZERO: op_c = OP_ZERO;
      default: begin
        case (func_code)
          FN_ADD:  op_c = OP_ADD;
          FN_ADDU: op_c = OP_ADDU;
          FN_SUB:  op_c = OP_SUB;
          FN_SUBU: op_c = OP_SUBU;
          FN_AND:  op_c = OP_AND;
          FN_OR:   op_c = OP_OR;
          FN_XOR:  op_c = OP_XOR;
          FN_NOR:  op_c = OP_NOR;
          FN_SLT:  op_c = OP_SLT;
          FN_SLTU: op_c = OP_SLTU;
          FN_MFHI: op_c = OP_MFHI;
          FN_MFLO: op_c = OP_MFLO;
          FN_MULT: begin
            if (MUL_EN != 0) op_c = OP_MULT;
            else             illegal_c = 1'b1;
          end
          FN_MULTU: begin
            if (MUL_EN != 0) op_c = OP_MULTU;
            else             illegal_c = 1'b1;
          end
          default: illegal_c = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ALU ops plus an iterative shift-add multiplier into HI/LO.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  op_e                op_c;
  logic               dec_illegal_c;
  logic               accept_c, mul_start_c, mul_last_c;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [PW-1:0]      prod_q;
  logic [WIDTH-1:0]   mcand_q;
  logic               neg_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   sum_c, diff_c, alu_res_c;
  logic               alu_ovf_c;
  logic               mul_signed_c;
  logic [WIDTH-1:0]   mag_a_c, mag_b_c;
  logic [WIDTH:0]     add_c;
  logic [PW-1:0]      prod_nxt_c, final_c;

  alu_ctl_decode #(
    .MUL_EN(MUL_EN)
  ) u_decode (
    .alu_op    (alu_op),
    .func_code (func_code),
    .op_c      (op_c),
    .illegal_c (dec_illegal_c)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state, handshake and multiply sequencing strobes
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    accept_c    = 1'b0;
    mul_start_c = 1'b0;
    mul_last_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = !out_valid || out_ready;
        accept_c = in_valid && in_ready;
        if (accept_c && is_mul_op(op_c)) begin
          mul_start_c = 1'b1;
          state_d     = ST_MUL;
        end
      end
      ST_MUL: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          mul_last_c = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single-cycle ALU result and signed-overflow detection
  always_comb begin
    sum_c     = a + b;
    diff_c    = a - b;
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    case (op_c)
      OP_ADD: begin
        alu_res_c = sum_c;
        alu_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU: alu_res_c = sum_c;
      OP_SUB: begin
        alu_res_c = diff_c;
        alu_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUBU: alu_res_c = diff_c;
      OP_AND:  alu_res_c = a & b;
      OP_OR:   alu_res_c = a | b;
      OP_XOR:  alu_res_c = a ^ b;
      OP_NOR:  alu_res_c = ~(a | b);
      OP_SLT:  alu_res_c = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: alu_res_c = WIDTH'(a < b);
      OP_MFHI: alu_res_c = hi_q;
      OP_MFLO: alu_res_c = lo_q;
      default: alu_res_c = '0;
    endcase
  end

  // Multiplier: operand magnitudes at start, one shift-add step per cycle, sign fix on the last step
  always_comb begin
    mul_signed_c = (op_c == OP_MULT);
    mag_a_c      = (mul_signed_c && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    mag_b_c      = (mul_signed_c && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    add_c        = {1'b0, prod_q[PW-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
    prod_nxt_c   = {add_c, prod_q[WIDTH-1:1]};
    final_c      = neg_q ? (~prod_nxt_c + PW'(1)) : prod_nxt_c;
  end

  // Output registers, HI/LO and multiplier datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept_c) begin
        if (mul_start_c) begin
          out_valid <= 1'b0;
          prod_q    <= {{WIDTH{1'b0}}, mag_b_c};
          mcand_q   <= mag_a_c;
          neg_q     <= mul_signed_c && (a[WIDTH-1] ^ b[WIDTH-1]);
          cnt_q     <= '0;
        end else begin
          out_valid <= 1'b1;
          result    <= alu_res_c;
          zero      <= (alu_res_c == '0);
          overflow  <= alu_ovf_c;
          illegal   <= dec_illegal_c;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (state_q == ST_MUL) begin
        prod_q <= prod_nxt_c;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (mul_last_c) begin
          hi_q      <= final_c[PW-1:WIDTH];
          lo_q      <= final_c[WIDTH-1:0];
          cnt_q     <= '0;
          out_valid <= 1'b1;
          result    <= '0;
          zero      <= 1'b1;
          overflow  <= 1'b0;
          illegal   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes model expectations, monitor pops on output handshake.
module tb_alu_exec_unit;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    alu_op;
  logic [5:0]    func_code;
  logic [W-1:0]  a, b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero, overflow, illegal;

  alu_exec_unit #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .func_code (func_code),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic        il;
    int          acc;
    int          lat;
    bit          is_mul;
    logic [1:0]  op;
    logic [5:0]  fn;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          front_seen = 1'b0;
  bit          chk_en = 1'b0;
  bit          ready_force = 1'b1;
  logic        mon_ir;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          and_acc, or_acc, dummy_acc;
  bit          or_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural meaning of each op
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, s;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.res = '0; e.ov = 1'b0; e.il = 1'b0; e.lat = 1; e.is_mul = 1'b0;
    e.acc = 0; e.op = op; e.fn = fn;
    if (op == 2'b00 || (op == 2'b10 && fn == 6'h20)) begin
      s = sx + sy; e.res = x + y; e.ov = (s != longint'($signed(e.res)));
    end else if (op == 2'b01 || (op == 2'b10 && fn == 6'h22)) begin
      s = sx - sy; e.res = x - y; e.ov = (s != longint'($signed(e.res)));
    end else if (op == 2'b10) begin
      case (fn)
        6'h21: e.res = x + y;
        6'h23: e.res = x - y;
        6'h24: e.res = x & y;
        6'h25: e.res = x | y;
        6'h26: e.res = x ^ y;
        6'h27: e.res = ~(x | y);
        6'h2a: e.res = 32'(sx < sy);
        6'h2b: e.res = 32'(x < y);
        6'h18: begin
          p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; e.lat = 33; e.is_mul = 1'b1;
        end
        6'h19: begin
          p = {32'h0, x} * {32'h0, y}; m_hi = p[63:32]; m_lo = p[31:0]; e.lat = 33; e.is_mul = 1'b1;
        end
        6'h10: e.res = m_hi;
        6'h12: e.res = m_lo;
        default: e.il = 1'b1;
      endcase
    end
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  // Offer one op and wait (bounded) for acceptance; expectation queued at the accept cycle
  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] x, input logic [31:0] y, output int acc);
    int   waited;
    bit   ok;
    exp_t e;
    waited = 0;
    ok = 1'b0;
    acc = -1;
    @(negedge clk);
    alu_op = op; func_code = fn; a = x; b = y; in_valid = 1'b1;
    while (!ok && waited < 200) begin
      #2;
      if (in_ready) ok = 1'b1;
      else begin
        waited++;
        @(negedge clk);
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout op=%b fn=%h: in_ready stayed 0, expected acceptance", op, fn);
      in_valid = 1'b0;
      return;
    end
    e = model(op, fn, x, y);
    e.acc = cyc;
    acc = cyc;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
      front_seen = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Consumer back-pressure, random unless a directed test owns it
  always @(negedge clk) if (!ready_force) out_ready = ($urandom_range(0, 3) != 0);

  // Monitor: checks in_ready every cycle and every presented result against the queue head
  always @(negedge clk) begin
    #1;
    if (chk_en && !rst) begin
      mon_ir = !out_valid || out_ready;
      if (!out_valid && q.size() > 0 && q[0].is_mul) mon_ir = 1'b0;
      chk("in_ready", 64'(in_ready), 64'(mon_ir));
      if (out_valid) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out_valid at cycle %0d: got out_valid=1, expected no pending op", cyc);
        end else begin
          if (!front_seen) begin
            chk($sformatf("latency op=%b fn=%h", q[0].op, q[0].fn), 64'(cyc - q[0].acc), 64'(q[0].lat));
            front_seen = 1'b1;
          end
          chk($sformatf("result op=%b fn=%h", q[0].op, q[0].fn), 64'(result), 64'(q[0].res));
          chk($sformatf("zero op=%b fn=%h", q[0].op, q[0].fn), 64'(zero), 64'(q[0].z));
          chk($sformatf("overflow op=%b fn=%h", q[0].op, q[0].fn), 64'(overflow), 64'(q[0].ov));
          chk($sformatf("illegal op=%b fn=%h", q[0].op, q[0].fn), 64'(illegal), 64'(q[0].il));
          if (out_ready) begin
            void'(q.pop_front());
            front_seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int          r;
    logic [5:0]  fns [15];
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2a, 6'h2b, 6'h18, 6'h19, 6'h10, 6'h12, 6'h3f};
    rst = 1'b1; in_valid = 1'b0; alu_op = '0; func_code = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_result", 64'(result), 64'(0));
    chk("reset_zero", 64'(zero), 64'(0));
    chk("reset_overflow", 64'(overflow), 64'(0));
    chk("reset_illegal", 64'(illegal), 64'(0));
    chk_en = 1'b1;

    // Directed arithmetic corners, back to back
    issue(2'b10, 6'h20, 32'h7FFFFFFF, 32'h1, dummy_acc);
    issue(2'b10, 6'h21, 32'h7FFFFFFF, 32'h1, dummy_acc);
    issue(2'b01, 6'h00, 32'd5, 32'd5, dummy_acc);
    issue(2'b10, 6'h2a, 32'hFFFFFFFF, 32'h1, dummy_acc);
    issue(2'b10, 6'h2b, 32'hFFFFFFFF, 32'h1, dummy_acc);
    issue(2'b10, 6'h3f, 32'h1234, 32'h5678, dummy_acc);
    issue(2'b11, 6'h20, 32'h1234, 32'h5678, dummy_acc);
    issue(2'b00, 6'h00, 32'h80000000, 32'h80000000, dummy_acc);

    // Multiply then HI/LO reads that stall behind it
    issue(2'b10, 6'h18, 32'hFFFFFFFD, 32'd7, dummy_acc);
    issue(2'b10, 6'h12, 32'h0, 32'h0, dummy_acc);
    issue(2'b10, 6'h10, 32'h0, 32'h0, dummy_acc);
    issue(2'b10, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, dummy_acc);
    issue(2'b10, 6'h10, 32'h0, 32'h0, dummy_acc);
    issue(2'b10, 6'h12, 32'h0, 32'h0, dummy_acc);
    drain();

    // Back-pressure hold: AND held 4 cycles, queued OR accepted as AND is taken
    @(negedge clk);
    out_ready = 1'b0;
    or_done = 1'b0;
    issue(2'b10, 6'h24, 32'hF0F0A5A5, 32'h0FF0FFFF, and_acc);
    fork
      begin
        issue(2'b10, 6'h25, 32'h00FF0000, 32'h0000FF00, or_acc);
        or_done = 1'b1;
      end
    join_none
    repeat (4) @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 250 && !or_done; i++) @(negedge clk);
    chk("or_accept_cycle", 64'(or_acc), 64'(and_acc + 5));
    drain();

    // Reset in the middle of a multiply
    issue(2'b10, 6'h18, 32'd12345, 32'hFFFF0001, dummy_acc);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    q.delete();
    front_seen = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midmul_rst_out_valid", 64'(out_valid), 64'(0));
    chk("midmul_rst_in_ready", 64'(in_ready), 64'(1));
    repeat (40) @(negedge clk);
    issue(2'b10, 6'h10, 32'h0, 32'h0, dummy_acc);
    issue(2'b10, 6'h12, 32'h0, 32'h0, dummy_acc);
    drain();

    // Randomized traffic with random back-pressure
    @(negedge clk);
    ready_force = 1'b0;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      issue(2'b00, 6'($urandom), pick(), pick(), dummy_acc);
      else if (r == 1) issue(2'b01, 6'($urandom), pick(), pick(), dummy_acc);
      else if (r == 2) issue(2'b11, 6'($urandom), pick(), pick(), dummy_acc);
      else if (r == 3) issue(2'b10, 6'($urandom), pick(), pick(), dummy_acc);
      else             issue(2'b10, fns[$urandom_range(0, 14)], pick(), pick(), dummy_acc);
    end
    drain();
    @(negedge clk);
    ready_force = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
